// File: rtl/rr_mux2_pkg.sv
// Shared encodings for the round-robin 2:1 mux arbiter: output-stage states and mux select values.
package rr_mux2_pkg;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/rr_mux2_grant.sv
// Combinational round-robin grant between channels A and B.
// On a tie the channel that did not win the previous grant is chosen.
module rr_mux2_grant
    import rr_mux2_pkg::*;
(
    input  logic a_valid,
    input  logic b_valid,
    input  logic last,
    output logic grant_vld,
    output logic grant_sel
);

    always_comb begin
        grant_vld = a_valid | b_valid;
        grant_sel = SEL_A;
        if (a_valid && b_valid) begin
            grant_sel = (last == SEL_A) ? SEL_B : SEL_A;
        end else if (b_valid) begin
            grant_sel = SEL_B;
        end
    end

endmodule

// File: rtl/rr_mux2_arbiter.sv
// Round-robin arbiter for two valid/ready channels feeding a one-entry registered output stage.
// Optional saturating per-channel grant counters are built when RR_MUX2_COUNT_EN is defined.
module rr_mux2_arbiter
    import rr_mux2_pkg::*;
#(
    parameter int WIDTH = 8
`ifdef RR_MUX2_COUNT_EN
    ,
    parameter int COUNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             sel
`ifdef RR_MUX2_COUNT_EN
    ,
    output logic [COUNT_W-1:0] cnt_a,
    output logic [COUNT_W-1:0] cnt_b
`endif
);

    state_t           state_p1;
    state_t           state_nxt;
    logic             last_p1;
    logic             sel_p1;
    logic [WIDTH-1:0] data_p1;

    logic             grant_vld;
    logic             grant_sel;
    logic             load;
    logic             take;
    logic [WIDTH-1:0] mux_data;

    rr_mux2_grant u_grant (
        .a_valid   (a_valid),
        .b_valid   (b_valid),
        .last      (last_p1),
        .grant_vld (grant_vld),
        .grant_sel (grant_sel)
    );

    // Stage p0: grant, handshake and 2:1 data mux (all combinational)
    always_comb begin
        load     = (state_p1 == ST_EMPTY) || out_ready;
        take     = load && grant_vld;
        a_ready  = take && (grant_sel == SEL_A);
        b_ready  = take && (grant_sel == SEL_B);
        mux_data = (grant_sel == SEL_B) ? b_data : a_data;
    end

    always_comb begin
        state_nxt = state_p1;
        case (state_p1)
            ST_EMPTY: begin
                if (take) state_nxt = ST_FULL;
            end
            ST_FULL: begin
                // A drain with a simultaneous grant stays FULL for full throughput
                if (out_ready && !take) state_nxt = ST_EMPTY;
            end
            default: state_nxt = ST_EMPTY;
        endcase
    end

    // Stage p1: registered output word, select and fairness pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_p1 <= ST_EMPTY;
        end else begin
            state_p1 <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_p1 <= '0;
            sel_p1  <= SEL_A;
            last_p1 <= SEL_B;
        end else if (take) begin
            data_p1 <= mux_data;
            sel_p1  <= grant_sel;
            last_p1 <= grant_sel;
        end
    end

    assign out_valid = (state_p1 == ST_FULL);
    assign out_data  = data_p1;
    assign sel       = sel_p1;

`ifdef RR_MUX2_COUNT_EN
    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [COUNT_W-1:0] cnt_a_p1;
    logic [COUNT_W-1:0] cnt_b_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_a_p1 <= '0;
            cnt_b_p1 <= '0;
        end else begin
            if (a_ready) cnt_a_p1 <= sat_inc(cnt_a_p1);
            if (b_ready) cnt_b_p1 <= sat_inc(cnt_b_p1);
        end
    end

    assign cnt_a = cnt_a_p1;
    assign cnt_b = cnt_b_p1;
`endif

endmodule
